spi_char_master: RTL and testbench

//   SPI mode-0 master that sends ASCII bytes to the text-mode display's SPI slave.

---
 rtl/spi_char_master.sv | 208 ++++++++++++++++++++
 tb/tb_spi_char_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_char_master.sv
// SPI mode-0 master for the text-mode display's SPI slave.
// Bytes are queued through a valid/ready FIFO and each one is sent MSB first
// in its own chip-select frame, because the display commits a character on
// the cs rising edge. A frame is SETUP (CLK_DIV cycles of sck low), SHIFT
// (16 sck half-periods of CLK_DIV cycles, starting low), and HOLD (CLK_DIV
// cycles of sck low). That keeps cs low for exactly 18*CLK_DIV cycles. cs
// then stays high for CS_GAP cycles plus the single IDLE cycle that pops the
// next byte.
module spi_char_master #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CS_GAP     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy,
  output logic                              sck,
  output logic                              mosi,
  output logic                              cs
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int HP_W  = $clog2(CLK_DIV);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // FIFO storage and pointers
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Frame sequencer state
  state_t           state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [2:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [6:0]       rem_q, rem_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;

  logic push;
  logic pop;

  // Ready comes straight from the current count, so a same-cycle pop never
  // frees a slot for a push while the FIFO is full.
  assign tx_ready = (count_q != FULL_CNT);
  assign push     = tx_valid && tx_ready;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);

  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign sck        = sck_q;
  assign mosi       = mosi_q;
  assign cs         = cs_q;

  // FIFO pointer and occupancy update; pointers wrap at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: next state, counters, shift register and SPI pin values
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    case (state_q)
      ST_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (pop) begin
          rem_d   = mem_q[rd_ptr_q][6:0];
          mosi_d  = mem_q[rd_ptr_q][7];
          cs_d    = 1'b0;
          hp_d    = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (hp_q == HP_LAST) begin
          hp_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      ST_SHIFT: begin
        if (hp_q == HP_LAST) begin
          hp_d  = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling edge: advance to the next bit, or finish after the 8th
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = ST_HOLD;
            end else begin
              bit_d  = bit_q + 3'd1;
              mosi_d = rem_q[6];
              rem_d  = {rem_q[5:0], 1'b0};
            end
          end
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      ST_HOLD: begin
        if (hp_q == HP_LAST) begin
          hp_d    = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  // Control registers; reset aborts any frame at once and empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hp_q     <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data registers: FIFO slots are written on handshake, the remaining-bits register follows the sequencer
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
    rem_q <= rem_d;
  end

endmodule

// File: tb/tb_spi_char_master.sv
// Bench for spi_char_master (CLK_DIV=4, FIFO_DEPTH=8, CS_GAP=4).
// A negedge monitor keeps an abstract model (queue of accepted bytes, byte
// count, SPI frame decoder) and compares the DUT with it every cycle.
// Directed tests add hand-computed literal expectations.
module tb_spi_char_master;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CS_GAP     = 4;
  localparam int FRAME_LOW  = 18 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] fifo_count;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       cs;

  int errors = 0;
  int checks = 0;

  spi_char_master #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CS_GAP    (CS_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .fifo_count(fifo_count),
    .busy      (busy),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int         m_count = 0;
  bit         pend_push = 0;
  logic [7:0] pend_data = 8'h00;
  bit         p_cs = 1, p_sck = 0, p_mosi = 0;
  int         low_len = 0, hi_len = 0, rises = 0, total_rises = 0;
  int         since_rise = CS_GAP;
  logic [7:0] shreg = 8'h00;
  bit         had_frame = 0, gap_exact = 0, saw_full = 0;
  int         last_low_len = 0;
  int         last_sck_at_end = -1;

  function automatic int get_log(input int idx);
    if (idx < 0 || idx >= log_q.size()) return -1;
    return int'(log_q[idx]);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {cs, sck, mosi, busy, tx_ready, fifo_count}, {5'b10001, 4'd0});
      exp_q.delete();
      m_count    = 0;
      pend_push  = 0;
      p_cs       = 1;
      p_sck      = 0;
      p_mosi     = 0;
      low_len    = 0;
      hi_len     = 0;
      rises      = 0;
      since_rise = CS_GAP;
      had_frame  = 0;
      gap_exact  = 0;
    end else begin
      if (pend_push) begin
        exp_q.push_back(pend_data);
        m_count++;
      end
      if (p_cs && !cs) begin
        m_count--;
        if (had_frame) begin
          if (gap_exact) check("cs_gap_exact", hi_len, CS_GAP + 1);
          else           check("cs_gap_min", int'(hi_len >= CS_GAP + 1), 1);
        end
        low_len = 0;
        rises   = 0;
      end
      if (!cs) low_len++;
      if (!p_sck && sck) begin
        rises++;
        total_rises++;
        shreg = {shreg[6:0], mosi};
      end
      if (!p_cs && cs) begin
        check("frame_rises", rises, 8);
        check("frame_cs_low_len", low_len, FRAME_LOW);
        check("sck_at_cs_rise", int'(sck), 0);
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          check("frame_byte", int'(shreg), int'(exp_q.pop_front()));
        end
        log_q.push_back(shreg);
        last_low_len    = low_len;
        last_sck_at_end = int'(sck);
        hi_len     = 0;
        had_frame  = 1;
        gap_exact  = (m_count > 0);
        since_rise = 0;
      end else if (since_rise < 100000) begin
        since_rise++;
      end
      if (cs) hi_len++;
      check("fifo_count", int'(fifo_count), m_count);
      check("tx_ready", int'(tx_ready), int'(m_count != FIFO_DEPTH));
      check("busy", int'(busy), int'((m_count != 0) || !cs || (since_rise < CS_GAP)));
      if (cs) check("sck_low_while_cs_high", int'(sck), 0);
      else    check("mosi_stable_while_sck_high", int'((mosi == p_mosi) || !sck), 1);
      if (fifo_count == 4'(FIFO_DEPTH) && !tx_ready) saw_full = 1;
      pend_push = tx_valid && tx_ready;
      pend_data = tx_data;
      p_cs      = cs;
      p_sck     = sck;
      p_mosi    = mosi;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change only at posedge+1 so the monitor's negedge sample matches the next edge.
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !cs) && n < bound);
    check(name, int'(!busy && cs), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r, snap_r, snap_log;
    bit ps;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t1_idle_lines", {cs, sck, mosi, tx_ready, busy}, 5'b10010);
    end
    @(posedge clk);
    #1;

    // Test 2: single byte 0x41
    base = log_q.size();
    push(8'h41);
    wait_idle("t2_drain", 500);
    check("t2_frames", log_q.size() - base, 1);
    check("t2_byte_bits", get_log(base), 8'b0100_0001);
    check("t2_cs_low", last_low_len, 72);
    check("t2_sck_at_end", last_sck_at_end, 0);

    // Test 3: 12 bytes back-to-back
    base = log_q.size();
    saw_full = 0;
    for (int i = 0; i < 12; i++) push(8'h30 + 8'(i));
    wait_idle("t3_drain", 3000);
    check("t3_frames", log_q.size() - base, 12);
    check("t3_saw_full", int'(saw_full), 1);
    for (int i = 0; i < 12; i++) check("t3_order", get_log(base + i), 8'h30 + i);

    // Test 5: full FIFO with simultaneous pop and push
    base = log_q.size();
    for (int i = 0; i < 9; i++) push(8'h61 + 8'(i));
    tx_data  = 8'h6A;
    tx_valid = 1'b1;
    @(negedge clk);
    check("t5_full_count", int'(fifo_count), 8);
    check("t5_full_ready", int'(tx_ready), 0);
    r = 0;
    while (!cs && r < 500) begin @(negedge clk); r++; end
    while (cs && r < 1000) begin @(negedge clk); r++; end
    check("t5_pop_count", int'(fifo_count), 7);
    check("t5_pop_ready", int'(tx_ready), 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("t5_next_push_count", int'(fifo_count), 8);
    wait_idle("t5_drain", 3000);
    check("t5_frames", log_q.size() - base, 10);
    for (int i = 0; i < 10; i++) check("t5_order", get_log(base + i), 8'h61 + i);

    // Test 4: reset after the 3rd sck rise of 0x5A
    base = log_q.size();
    push(8'h5A);
    push(8'h33);
    r  = 0;
    ps = sck;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sck && !ps) r++;
      ps = sck;
      if (r == 3) break;
    end
    check("t4_third_rise", r, 3);
    check("t4_queued_before", int'(fifo_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_cs", int'(cs), 1);
    check("t4_async_sck", int'(sck), 0);
    check("t4_async_count", int'(fifo_count), 0);
    check("t4_async_ready", int'(tx_ready), 1);
    check("t4_async_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    snap_r   = total_rises;
    snap_log = log_q.size();
    repeat (60) @(negedge clk);
    #1;
    check("t4_no_sck_after", total_rises - snap_r, 0);
    check("t4_no_frame_after", log_q.size() - snap_log, 0);
    check("t4_count_after", int'(fifo_count), 0);
    check("t4_frames", log_q.size() - base, 0);
    @(posedge clk);
    #1;

    // Test 6: loopback-style decode of 0x00, 0xFF, 0x5A, 0x7E
    base = log_q.size();
    push(8'h00);
    push(8'hFF);
    push(8'h5A);
    push(8'h7E);
    wait_idle("t6_drain", 2000);
    check("t6_frames", log_q.size() - base, 4);
    check("t6_byte0", get_log(base + 0), 8'h00);
    check("t6_byte1", get_log(base + 1), 8'hFF);
    check("t6_byte2", get_log(base + 2), 8'h5A);
    check("t6_byte3", get_log(base + 3), 8'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
